// File: rtl/mac_wlcontrol.sv
// Word-line controller for one MAC array operation: DAC load, arm, WL pulse, DAC discharge.
// Optional ARM timeout is enabled by defining MAC_WL_TIMEOUT_EN.
module mac_wlcontrol #(
  parameter logic [7:0]  TIME_DAC    = 8'd10,
  parameter logic [7:0]  VOL_SET     = 8'h80,
  parameter logic [7:0]  VOL_RESET   = 8'hC0,
  parameter logic [7:0]  VOL_READ    = 8'h60
`ifdef MAC_WL_TIMEOUT_EN
  ,
  parameter logic [15:0] ARM_TIMEOUT = 16'd1000
`endif
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       work_en,
  input  logic       work_mode,
  input  logic       op_mode,
  input  logic [4:0] wl_addr_in,
  input  logic [7:0] pulse_width,
  input  logic       bl_assert_en,
  output logic [7:0] wl_digital_vol,
  output logic       wl_dac_lock_en,
  output logic [4:0] wl_addr,
  output logic       wl_pulse_en,
  output logic       op_down,
  output logic       wl_busy,
  output logic       op_done,
  output logic       wl_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DAC_SET = 3'd1,
    ARM     = 3'd2,
    PULSE   = 3'd3,
    RECOVER = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] timer_q;
  logic [7:0] pcnt_q;
  logic [7:0] width_q;
  logic [7:0] vol_q;
  logic       lock_q;
  logic [4:0] addr_q;
  logic       pulse_q;
  logic       op_down_q;
  logic       busy_q;
  logic       op_done_q;
  logic [7:0] width_d;
  logic [7:0] vol_d;

  // A zero width still produces a single-cycle pulse.
  assign width_d = (pulse_width == 8'd0) ? 8'd1 : pulse_width;
  assign vol_d   = work_mode ? (op_mode ? VOL_SET : VOL_RESET) : VOL_READ;

`ifdef MAC_WL_TIMEOUT_EN
  logic [15:0] arm_cnt_q;
  logic        err_q;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      timer_q   <= 8'd0;
      pcnt_q    <= 8'd0;
      width_q   <= 8'd0;
      vol_q     <= 8'd0;
      lock_q    <= 1'b0;
      addr_q    <= 5'd0;
      pulse_q   <= 1'b0;
      op_down_q <= 1'b0;
      busy_q    <= 1'b0;
      op_done_q <= 1'b0;
`ifdef MAC_WL_TIMEOUT_EN
      arm_cnt_q <= 16'd0;
      err_q     <= 1'b0;
`endif
    end else begin
      lock_q    <= 1'b0;
      op_done_q <= 1'b0;
`ifdef MAC_WL_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (work_en) begin
            state_q <= DAC_SET;
            busy_q  <= 1'b1;
            addr_q  <= wl_addr_in;
            width_q <= width_d;
            vol_q   <= vol_d;
            lock_q  <= 1'b1;
            timer_q <= TIME_DAC;
          end
        end
        DAC_SET: begin
          if (timer_q == 8'd1) begin
            state_q <= ARM;
            timer_q <= 8'd0;
`ifdef MAC_WL_TIMEOUT_EN
            arm_cnt_q <= 16'd0;
`endif
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        ARM: begin
          if (bl_assert_en) begin
            state_q   <= PULSE;
            pulse_q   <= 1'b1;
            pcnt_q    <= width_q;
            op_down_q <= (width_q == 8'd1);
`ifdef MAC_WL_TIMEOUT_EN
            arm_cnt_q <= 16'd0;
          end else if (arm_cnt_q == ARM_TIMEOUT - 16'd1) begin
            // BL side never answered: abandon the pulse and discharge the DAC.
            state_q   <= RECOVER;
            err_q     <= 1'b1;
            vol_q     <= 8'd0;
            lock_q    <= 1'b1;
            timer_q   <= TIME_DAC;
            arm_cnt_q <= 16'd0;
          end else begin
            arm_cnt_q <= arm_cnt_q + 16'd1;
`endif
          end
        end
        PULSE: begin
          if (pcnt_q == 8'd1) begin
            state_q   <= RECOVER;
            pulse_q   <= 1'b0;
            op_down_q <= 1'b0;
            vol_q     <= 8'd0;
            lock_q    <= 1'b1;
            timer_q   <= TIME_DAC;
            pcnt_q    <= 8'd0;
          end else begin
            pcnt_q    <= pcnt_q - 8'd1;
            op_down_q <= (pcnt_q == 8'd2);
          end
        end
        RECOVER: begin
          if (timer_q == 8'd1) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            op_done_q <= 1'b1;
            timer_q   <= 8'd0;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wl_digital_vol = vol_q;
  assign wl_dac_lock_en = lock_q;
  assign wl_addr        = addr_q;
  assign wl_pulse_en    = pulse_q;
  assign op_down        = op_down_q;
  assign wl_busy        = busy_q;
  assign op_done        = op_done_q;
`ifdef MAC_WL_TIMEOUT_EN
  assign wl_err         = err_q;
`else
  assign wl_err         = 1'b0;
`endif

endmodule

// File: tb/tb_mac_wlcontrol.sv
// Directed self-checking bench for mac_wlcontrol; inputs change and outputs are sampled on the falling edge.
// With MAC_WL_TIMEOUT_EN defined the DUT is built with ARM_TIMEOUT = 50.
module tb_mac_wlcontrol;

  logic       sysClk = 1'b0;
  logic       sysRstN = 1'b0;
  logic       workEn = 1'b0;
  logic       workMode = 1'b0;
  logic       opMode = 1'b0;
  logic [4:0] wlAddrIn = 5'd0;
  logic [7:0] pulseWidth = 8'd0;
  logic       blAssertEn = 1'b0;
  logic [7:0] wlDigitalVol;
  logic       wlDacLockEn;
  logic [4:0] wlAddr;
  logic       wlPulseEn;
  logic       opDown;
  logic       wlBusy;
  logic       opDone;
  logic       wlErr;

  int checkCount = 0;
  int passCount = 0;
  int failCount = 0;

  always #5 sysClk = ~sysClk;

`ifdef MAC_WL_TIMEOUT_EN
  mac_wlcontrol #(.ARM_TIMEOUT(16'd50)) dut (
`else
  mac_wlcontrol dut (
`endif
    .sys_clk        (sysClk),
    .sys_rst_n      (sysRstN),
    .work_en        (workEn),
    .work_mode      (workMode),
    .op_mode        (opMode),
    .wl_addr_in     (wlAddrIn),
    .pulse_width    (pulseWidth),
    .bl_assert_en   (blAssertEn),
    .wl_digital_vol (wlDigitalVol),
    .wl_dac_lock_en (wlDacLockEn),
    .wl_addr        (wlAddr),
    .wl_pulse_en    (wlPulseEn),
    .op_down        (opDown),
    .wl_busy        (wlBusy),
    .op_done        (opDone),
    .wl_err         (wlErr)
  );

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkFlag(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge sysClk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " vol"}, wlDigitalVol, 8'h00);
    checkOutput({tag, " addr"}, {3'b000, wlAddr}, 8'h00);
    checkFlag({tag, " lock"}, wlDacLockEn, 1'b0);
    checkFlag({tag, " pulse_en"}, wlPulseEn, 1'b0);
    checkFlag({tag, " op_down"}, opDown, 1'b0);
    checkFlag({tag, " busy"}, wlBusy, 1'b0);
    checkFlag({tag, " op_done"}, opDone, 1'b0);
    checkFlag({tag, " err"}, wlErr, 1'b0);
  endtask

  // Presents a request on the current falling edge and checks the DAC load one cycle later (cycle 1 of DAC_SET).
  task automatic applyStimulus(input logic mode, input logic op, input logic [4:0] addr,
                               input logic [7:0] pw, input logic [7:0] expVol, input logic hold);
    workEn = 1'b1;
    workMode = mode;
    opMode = op;
    wlAddrIn = addr;
    pulseWidth = pw;
    stepCycles(1);
    if (!hold) workEn = 1'b0;
    checkOutput("load vol", wlDigitalVol, expVol);
    checkFlag("load lock", wlDacLockEn, 1'b1);
    checkFlag("load busy", wlBusy, 1'b1);
    checkOutput("load addr", {3'b000, wlAddr}, {3'b000, addr});
    checkFlag("load pulse_en", wlPulseEn, 1'b0);
  endtask

  // Called with blAssertEn already high during an ARM cycle; follows the pulse through to op_done.
  task automatic runPulse(input int w);
    for (int i = 0; i < w; i++) begin
      stepCycles(1);
      if (i == 0) blAssertEn = 1'b0;
      checkFlag("pulse_en high", wlPulseEn, 1'b1);
      checkFlag("op_down", opDown, (i == w - 1));
    end
    stepCycles(1);
    checkFlag("pulse end pulse_en", wlPulseEn, 1'b0);
    checkFlag("pulse end op_down", opDown, 1'b0);
    checkOutput("discharge vol", wlDigitalVol, 8'h00);
    checkFlag("discharge lock", wlDacLockEn, 1'b1);
    checkFlag("recover busy", wlBusy, 1'b1);
    stepCycles(1);
    checkFlag("discharge lock single", wlDacLockEn, 1'b0);
    stepCycles(8);
    checkFlag("recover op_done early", opDone, 1'b0);
    checkFlag("recover busy late", wlBusy, 1'b1);
    stepCycles(1);
    checkFlag("op_done", opDone, 1'b1);
    checkFlag("idle busy", wlBusy, 1'b0);
  endtask

  initial begin
    #3;
    checkAllZero("reset");
    @(negedge sysClk);
    sysRstN = 1'b1;
    stepCycles(1);
    checkFlag("post reset busy", wlBusy, 1'b0);

    $display("[TB] write/set, W=4");
    applyStimulus(1'b1, 1'b1, 5'h13, 8'd4, 8'h80, 1'b0);
    wlAddrIn = 5'h1F;
    pulseWidth = 8'd9;
    workMode = 1'b0;
    stepCycles(1);
    checkFlag("set lock single", wlDacLockEn, 1'b0);
    checkOutput("set vol hold", wlDigitalVol, 8'h80);
    stepCycles(10);
    checkFlag("set arm no pulse", wlPulseEn, 1'b0);
    blAssertEn = 1'b1;
    runPulse(4);
    checkOutput("set addr hold", {3'b000, wlAddr}, 8'h13);
    stepCycles(1);
    checkFlag("set op_done single", opDone, 1'b0);

    $display("[TB] read, pulse_width=0, early bl_assert_en ignored");
    applyStimulus(1'b0, 1'b1, 5'h05, 8'd0, 8'h60, 1'b0);
    stepCycles(1);
    blAssertEn = 1'b1;
    stepCycles(1);
    blAssertEn = 1'b0;
    checkFlag("read early bl 1", wlPulseEn, 1'b0);
    stepCycles(6);
    blAssertEn = 1'b1;
    stepCycles(1);
    blAssertEn = 1'b0;
    checkFlag("read early bl 2", wlPulseEn, 1'b0);
    stepCycles(1);
    checkFlag("read arm no pulse", wlPulseEn, 1'b0);
    blAssertEn = 1'b1;
    runPulse(1);
    checkOutput("read addr hold", {3'b000, wlAddr}, 8'h05);

    $display("[TB] back-to-back reset mode, W=2");
    stepCycles(1);
    applyStimulus(1'b1, 1'b0, 5'h0A, 8'd2, 8'hC0, 1'b1);
    stepCycles(3);
    workEn = 1'b0;
    stepCycles(1);
    workEn = 1'b1;
    stepCycles(7);
    wlAddrIn = 5'h0B;
    blAssertEn = 1'b1;
    runPulse(2);
    stepCycles(1);
    workEn = 1'b0;
    checkFlag("b2b restart lock", wlDacLockEn, 1'b1);
    checkOutput("b2b restart vol", wlDigitalVol, 8'hC0);
    checkFlag("b2b restart busy", wlBusy, 1'b1);
    checkOutput("b2b restart addr", {3'b000, wlAddr}, 8'h0B);
    stepCycles(11);
    blAssertEn = 1'b1;
    runPulse(2);
    stepCycles(1);

    $display("[TB] ARM without bl_assert_en");
    applyStimulus(1'b1, 1'b1, 5'h1C, 8'd3, 8'h80, 1'b0);
    stepCycles(10);
`ifdef MAC_WL_TIMEOUT_EN
    for (int i = 0; i < 50; i++) begin
      checkFlag("arm err", wlErr, 1'b0);
      checkFlag("arm pulse_en", wlPulseEn, 1'b0);
      checkFlag("arm op_down", opDown, 1'b0);
      stepCycles(1);
    end
    checkFlag("timeout err", wlErr, 1'b1);
    checkFlag("timeout lock", wlDacLockEn, 1'b1);
    checkOutput("timeout vol", wlDigitalVol, 8'h00);
    checkFlag("timeout pulse_en", wlPulseEn, 1'b0);
    checkFlag("timeout op_down", opDown, 1'b0);
    stepCycles(1);
    checkFlag("timeout err single", wlErr, 1'b0);
    checkFlag("timeout lock single", wlDacLockEn, 1'b0);
    stepCycles(8);
    checkFlag("timeout op_done early", opDone, 1'b0);
    stepCycles(1);
    checkFlag("timeout op_done", opDone, 1'b1);
    checkFlag("timeout idle busy", wlBusy, 1'b0);
`else
    stepCycles(1000);
    checkFlag("no timeout busy", wlBusy, 1'b1);
    checkFlag("no timeout err", wlErr, 1'b0);
    checkFlag("no timeout pulse_en", wlPulseEn, 1'b0);
    checkFlag("no timeout op_done", opDone, 1'b0);
    sysRstN = 1'b0;
    #1;
    checkFlag("arm reset busy", wlBusy, 1'b0);
    stepCycles(1);
    sysRstN = 1'b1;
`endif
    stepCycles(1);

    $display("[TB] reset in pulse cycle 5 of W=20");
    applyStimulus(1'b1, 1'b1, 5'h07, 8'd20, 8'h80, 1'b0);
    stepCycles(11);
    blAssertEn = 1'b1;
    stepCycles(1);
    blAssertEn = 1'b0;
    checkFlag("long pulse start", wlPulseEn, 1'b1);
    stepCycles(4);
    checkFlag("long pulse cycle5", wlPulseEn, 1'b1);
    #2;
    sysRstN = 1'b0;
    #1;
    checkAllZero("mid-pulse reset");
    @(negedge sysClk);
    sysRstN = 1'b1;
    stepCycles(1);
    checkAllZero("after reset release");
    applyStimulus(1'b0, 1'b0, 5'h02, 8'd1, 8'h60, 1'b0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
